// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high time of a servo-style PWM input and
// converts it to the 8-bit position code consumed by the servo PWM generator.
module servo_pwm_decoder #(
    parameter int MIN_CYC       = 50000,
    parameter int STEP_CYC      = 196,
    parameter int MAX_PULSE_CYC = 125000,
    parameter int TIMEOUT_CYC   = 1250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pwm_in,
    output logic [7:0] data,
    output logic       valid,
    output logic       pulse_err,
    output logic       signal_lost
);
    localparam int HIGH_W = $clog2(MAX_PULSE_CYC + 2);
    localparam int GAP_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    localparam logic [HIGH_W-1:0] MIN_VAL   = HIGH_W'(MIN_CYC);
    localparam logic [HIGH_W-1:0] MAX_VAL   = HIGH_W'(MAX_PULSE_CYC);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_HIGH} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        sync_reg;
    logic [1:0]        prime_reg;
    logic              s, s_d, rise, fall, primed;
    logic [HIGH_W-1:0] high_cnt_reg, high_cnt_next;
    logic [STEP_W-1:0] step_cnt_reg, step_cnt_next;
    logic [7:0]        code_cnt_reg, code_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [7:0]        data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              pulse_err_reg, pulse_err_next;
    logic              lost_reg, lost_next;

    // The synchronizer only holds real samples two cycles after reset, so ARM
    // must not mistake the reset zeros for a low line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            prime_reg <= '0;
        end else begin
            sync_reg  <= {sync_reg[1:0], pwm_in};
            prime_reg <= {prime_reg[0], 1'b1};
        end
    end

    assign s      = sync_reg[1];
    assign s_d    = sync_reg[2];
    assign rise   = s & ~s_d;
    assign fall   = ~s & s_d;
    assign primed = prime_reg[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_ARM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!en) begin
            state_next = ST_ARM;
        end else begin
            case (state_reg)
                ST_ARM:  if (primed && !s) state_next = ST_IDLE;
                ST_IDLE: if (rise) state_next = ST_HIGH;
                ST_HIGH: begin
                    if (fall) begin
                        state_next = ST_IDLE;
                    end else if (s && high_cnt_reg == MAX_VAL) begin
                        state_next = ST_ARM;
                    end
                end
                default: state_next = ST_ARM;
            endcase
        end
    end

    always_comb begin
        high_cnt_next  = high_cnt_reg;
        step_cnt_next  = step_cnt_reg;
        code_cnt_next  = code_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        pulse_err_next = 1'b0;
        lost_next      = lost_reg;
        if (!en) begin
            high_cnt_next = '0;
            step_cnt_next = '0;
            code_cnt_next = '0;
            gap_cnt_next  = '0;
            lost_next     = 1'b1;
        end else begin
            // A rise restarts the gap timer even on the cycle it would expire.
            if (rise) begin
                gap_cnt_next = '0;
            end else if (gap_cnt_reg != GAP_MAX) begin
                gap_cnt_next = gap_cnt_reg + 1'b1;
                if (gap_cnt_reg == GAP_LAST) lost_next = 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (rise) begin
                        high_cnt_next = HIGH_W'(1);
                        step_cnt_next = '0;
                        code_cnt_next = '0;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        data_next  = code_cnt_reg;
                        valid_next = 1'b1;
                        lost_next  = 1'b0;
                    end else if (s) begin
                        high_cnt_next = high_cnt_reg + 1'b1;
                        if (high_cnt_reg == MAX_VAL) pulse_err_next = 1'b1;
                        if (high_cnt_reg >= MIN_VAL) begin
                            if (step_cnt_reg == STEP_LAST) begin
                                step_cnt_next = '0;
                                if (code_cnt_reg != 8'hFF) code_cnt_next = code_cnt_reg + 1'b1;
                            end else begin
                                step_cnt_next = step_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            high_cnt_reg  <= '0;
            step_cnt_reg  <= '0;
            code_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            pulse_err_reg <= 1'b0;
            lost_reg      <= 1'b1;
        end else begin
            high_cnt_reg  <= high_cnt_next;
            step_cnt_reg  <= step_cnt_next;
            code_cnt_reg  <= code_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            pulse_err_reg <= pulse_err_next;
            lost_reg      <= lost_next;
        end
    end

    assign data        = data_reg;
    assign valid       = valid_reg;
    assign pulse_err   = pulse_err_reg;
    assign signal_lost = lost_reg;
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with scaled-down timing so every scenario,
// including the loss-of-signal timeout, fits in a short run.
module tb_servo_pwm_decoder;
    localparam int MIN  = 16;
    localparam int STEP = 3;
    localparam int MAXP = 900;
    localparam int TO   = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       pwm_in = 1'b1;
    logic [7:0] data;
    logic       valid, pulse_err, signal_lost;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int both_cnt = 0;
    int v_cyc[$];
    int v_dat[$];
    int e_cyc[$];
    int exp_data = 0;
    bit exp_lost = 1'b1;

    typedef struct {
        int h;
        int lo;
        bit err;
        int code;
    } vec_t;
    vec_t tbl[14];

    servo_pwm_decoder #(
        .MIN_CYC(MIN),
        .STEP_CYC(STEP),
        .MAX_PULSE_CYC(MAXP),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .pwm_in(pwm_in),
        .data(data),
        .valid(valid),
        .pulse_err(pulse_err),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(int'(data));
        end
        if (pulse_err) e_cyc.push_back(cyc);
        if (valid && pulse_err) both_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end before 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int model_code(input int h);
        int c;
        if (h < MIN) return 0;
        c = (h - MIN) / STEP;
        return (c > 255) ? 255 : c;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic clear_events();
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
    endtask

    task automatic pulse(input int h, input int lo, output int t_rise, output int t_fall);
        clear_events();
        @(posedge clk);
        #1 pwm_in = 1'b1;
        t_rise = cyc;
        repeat (h) @(posedge clk);
        #1 pwm_in = 1'b0;
        t_fall = cyc;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic check_pulse(input string nm, input bit err, input int code,
                               input int t_rise, input int t_fall);
        if (err) begin
            chk($sformatf("%s err count", nm), e_cyc.size(), 1);
            if (e_cyc.size() == 1) chk($sformatf("%s err cycle", nm), e_cyc[0], t_rise + MAXP + 3);
            chk($sformatf("%s valid count", nm), v_cyc.size(), 0);
        end else begin
            chk($sformatf("%s valid count", nm), v_cyc.size(), 1);
            if (v_cyc.size() == 1) begin
                chk($sformatf("%s valid cycle", nm), v_cyc[0], t_fall + 3);
                chk($sformatf("%s valid data", nm), v_dat[0], code);
            end
            chk($sformatf("%s err count", nm), e_cyc.size(), 0);
            exp_lost = 1'b0;
        end
        exp_data = code;
        chk($sformatf("%s data", nm), int'(data), exp_data);
        chk($sformatf("%s signal_lost", nm), int'(signal_lost), int'(exp_lost));
    endtask

    initial begin
        int tr, tf, h, lo;
        bit err;
        int code;

        tbl[0]  = '{16,  8, 1'b0, 0};
        tbl[1]  = '{397, 8, 1'b0, 127};
        tbl[2]  = '{781, 8, 1'b0, 255};
        tbl[3]  = '{850, 8, 1'b0, 255};
        tbl[4]  = '{10,  8, 1'b0, 0};
        tbl[5]  = '{18,  8, 1'b0, 0};
        tbl[6]  = '{19,  8, 1'b0, 1};
        tbl[7]  = '{399, 8, 1'b0, 127};
        tbl[8]  = '{400, 8, 1'b0, 128};
        tbl[9]  = '{900, 8, 1'b0, 255};
        tbl[10] = '{950, 8, 1'b1, 255};
        tbl[11] = '{397, 8, 1'b0, 127};
        tbl[12] = '{901, 8, 1'b1, 127};
        tbl[13] = '{1,   8, 1'b0, 0};

        // Reset with the line already high.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset data", int'(data), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset pulse_err", int'(pulse_err), 0);
        chk("reset signal_lost", int'(signal_lost), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_events();
        repeat (30) @(posedge clk);
        #1;
        chk("armed high valid count", v_cyc.size(), 0);
        chk("armed high err count", e_cyc.size(), 0);
        chk("armed high signal_lost", int'(signal_lost), 1);
        chk("armed high data", int'(data), 0);
        pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("armed low valid count", v_cyc.size(), 0);
        chk("armed low signal_lost", int'(signal_lost), 1);

        for (int i = 0; i < 14; i++) begin
            pulse(tbl[i].h, tbl[i].lo, tr, tf);
            $display("vec %0d: H=%0d data=%0d valid_events=%0d err_events=%0d lost=%0d",
                     i, tbl[i].h, data, v_cyc.size(), e_cyc.size(), signal_lost);
            check_pulse($sformatf("vec%0d H=%0d", i, tbl[i].h), tbl[i].err, tbl[i].code, tr, tf);
        end

        for (int i = 0; i < 25; i++) begin
            h  = int'($urandom_range(1, MAXP + 80));
            lo = int'($urandom_range(4, 40));
            err = (h > MAXP);
            code = err ? exp_data : model_code(h);
            pulse(h, lo, tr, tf);
            $display("rnd %0d: H=%0d data=%0d valid_events=%0d err_events=%0d lost=%0d",
                     i, h, data, v_cyc.size(), e_cyc.size(), signal_lost);
            check_pulse($sformatf("rnd%0d H=%0d", i, h), err, code, tr, tf);
        end

        // Loss of signal after a good frame, then recovery.
        pulse(100, 5, tr, tf);
        check_pulse("pre-timeout", 1'b0, 28, tr, tf);
        do @(negedge clk); while (cyc < tr + TO + 2);
        chk("lost before timeout", int'(signal_lost), 0);
        @(negedge clk);
        chk("lost at timeout", int'(signal_lost), 1);
        chk("data held after timeout", int'(data), 28);
        $display("timeout: cycle=%0d lost=%0d data=%0d", cyc, signal_lost, data);
        exp_lost = 1'b1;
        repeat (50) @(posedge clk);
        pulse(781, 8, tr, tf);
        check_pulse("resume", 1'b0, 255, tr, tf);

        // Enable dropped mid-pulse, re-enabled while the line is high.
        clear_events();
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (100) @(posedge clk);
        #1 en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("en off signal_lost", int'(signal_lost), 1);
        exp_lost = 1'b1;
        pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 en = 1'b1;
        repeat (200) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("en: valid_events=%0d err_events=%0d lost=%0d data=%0d",
                 v_cyc.size(), e_cyc.size(), signal_lost, data);
        chk("en discard valid count", v_cyc.size(), 0);
        chk("en discard err count", e_cyc.size(), 0);
        chk("en discard signal_lost", int'(signal_lost), 1);
        chk("en discard data", int'(data), exp_data);
        pulse(397, 8, tr, tf);
        check_pulse("after re-enable", 1'b0, 127, tr, tf);

        chk("valid/pulse_err overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generator. Measures the high time of an external servo-style PWM input and converts it to the same 8-bit position code the generator consumes.
- Used to capture positions from a hand-driven or RC servo signal for record/playback into the servo position memories.
- Also used as a loopback checker on the arm's GPIO servo outputs.

Parameters:
- MIN_CYC, 50000: high time (clk cycles) that maps to code 0; 1.0 ms at 50 MHz.
- STEP_CYC, 196: clk cycles per code step above MIN_CYC; 255 steps span about 1.0 ms.
- MAX_PULSE_CYC, 125000: longest legal high time (2.5 ms); longer pulses are errors.
- TIMEOUT_CYC, 1250000: maximum gap between rising edges (25 ms) before the signal is declared lost.

Ports:
- clk, input, 1: system clock, MAX10_CLK1_50 domain.
- rst_n, input, 1: synchronous reset, active low.
- en, input, 1: decoder enable, same role as the PWM en (SW[0]).
- pwm_in, input, 1: asynchronous servo PWM input.
- data, output, 8: last decoded position code.
- valid, output, 1: one-cycle strobe when data is updated.
- pulse_err, output, 1: one-cycle strobe when a pulse exceeds MAX_PULSE_CYC.
- signal_lost, output, 1: level; high when no valid pulse is being received.

Behaviour:
- Reset (rst_n=0 at a clk edge), all outputs and state:
  - data=0, valid=0, pulse_err=0, signal_lost=1.
  - Synchronizer flops = 0; counters = 0; FSM = ARM.
- Input sync: 2-flop synchronizer then an edge detector on the second stage (s).
  - Rise = s & ~s_d. Fall = ~s & s_d.
  - All timing below is measured on s.
- FSM states:
  - ARM: wait for s=0. Prevents measuring a pulse already in progress at reset or enable. Then go to IDLE.
  - IDLE: on rise go to HIGH. On rise, high_cnt=1, code_cnt=0, step_cnt=0, gap_cnt=0.
  - HIGH, each cycle with s=1:
    - high_cnt increments.
    - Once high_cnt ≥ MIN_CYC, step_cnt increments; on reaching STEP_CYC it wraps to 0 and code_cnt increments, saturating at 255.
    - Result: code = min(255, floor((H−MIN_CYC)/STEP_CYC)), or 0 if H<MIN_CYC, where H = number of cycles s was high.
  - HIGH, on fall with H ≤ MAX_PULSE_CYC:
    - Next cycle: data=code, valid=1 for 1 cycle, signal_lost=0.
    - Go to IDLE.
  - HIGH, when high_cnt reaches MAX_PULSE_CYC+1 with s still 1:
    - pulse_err=1 for 1 cycle; data unchanged; no valid.
    - Go to ARM, which waits for the line to go low.
- Latency: pwm_in falling edge to valid = 3 clk cycles (2 sync + 1 register).
- Timeout:
  - gap_cnt counts every enabled cycle and is cleared on each rise.
  - When gap_cnt reaches TIMEOUT_CYC, signal_lost=1 and gap_cnt saturates. FSM state is not disturbed.
  - data holds its last value.
  - signal_lost clears only on the next valid.
- en=0:
  - FSM forced to ARM; counters cleared.
  - valid=0, pulse_err=0, signal_lost=1; data holds.
  - A pulse in progress when en falls is discarded.
  - The synchronizer keeps running.
- Simultaneous events:
  - Fall on the same cycle high_cnt would exceed MAX_PULSE_CYC: the pulse is legal (H=MAX_PULSE_CYC); valid, no error.
  - Timeout on the same cycle as a rise: the rise wins, gap_cnt cleared, signal_lost unchanged.
- Widths:
  - high_cnt: ceil(log2(MAX_PULSE_CYC+2)).
  - gap_cnt: ceil(log2(TIMEOUT_CYC+1)).
  - step_cnt: ceil(log2(STEP_CYC)).
  - All compares are unsigned.
  - valid and pulse_err are never high in the same cycle.

Test Plan:
- Reset with pwm_in=1 held, then release → no valid until pwm_in goes low then high. data=0 and signal_lost=1 throughout.
- 20 ms frames, 1 ms high (H=50000) → data=0x00, valid one cycle, 3 cycles after the falling edge; signal_lost drops to 0.
- H=75000 → data=127 (0x7F). H=100000 → data=255. H=110000 → data=255 (clamp). H=30000 → data=0.
- H=130000 → pulse_err strobe at high_cnt=125001, data holds 255, no valid. The next 1.5 ms pulse → data=127.
- Stop the input after a valid frame → signal_lost=1 exactly TIMEOUT_CYC cycles after the last synchronized rise; data held. Resume with a 2 ms pulse → valid, data=255, signal_lost=0.
- Drop en mid-pulse → no valid, signal_lost=1. Re-enable with the line high → that pulse is ignored (ARM); the following pulse decodes normally.
